// File: rtl/cam_alloc_pkg.sv
// Shared constants and types for the multi-resource CU allocation CAM.
package cam_alloc_pkg;
  localparam int DEF_CU_ID_WIDTH = 6;
  localparam int DEF_NUMBER_CU   = 64;
  localparam int RES_ID_WIDTH    = 10;
  localparam int NUM_RES         = 3;
  localparam int W               = RES_ID_WIDTH + 1;

  typedef logic [W-1:0] count_t;
  // Channel k occupies bits [k*W +: W].
  typedef count_t [NUM_RES-1:0] size_t;
endpackage

// File: rtl/cam_allocator_mres_if.sv
// Search-request and result handshake bundle between the dispatcher and the allocation CAM.
interface cam_allocator_mres_if
  import cam_alloc_pkg::*;
#(
  parameter int CU_ID_WIDTH = DEF_CU_ID_WIDTH,
  parameter int NUMBER_CU   = DEF_NUMBER_CU
);
  logic                   search_valid;
  logic                   search_ready;
  size_t                  search_size;
  logic                   result_valid;
  logic                   result_ready;
  logic                   result_found;
  logic [CU_ID_WIDTH-1:0] result_cu_id;
  logic [NUMBER_CU-1:0]   result_mask;

  modport master (
    output search_valid, search_size, result_ready,
    input  search_ready, result_valid, result_found, result_cu_id, result_mask
  );

  modport slave (
    input  search_valid, search_size, result_ready,
    output search_ready, result_valid, result_found, result_cu_id, result_mask
  );
endinterface

// File: rtl/cam_alloc_prio_enc.sv
// Priority encoder that scans the fit mask starting at a given index and wrapping modulo NUMBER_CU.
module cam_alloc_prio_enc
  import cam_alloc_pkg::*;
#(
  parameter int CU_ID_WIDTH = DEF_CU_ID_WIDTH,
  parameter int NUMBER_CU   = DEF_NUMBER_CU
) (
  input  logic [NUMBER_CU-1:0]   mask,
  input  logic [CU_ID_WIDTH-1:0] start,
  output logic                   found,
  output logic [CU_ID_WIDTH-1:0] idx
);
  logic [CU_ID_WIDTH:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < NUMBER_CU; i++) begin
      pos = {1'b0, start} + (CU_ID_WIDTH+1)'(i);
      if (pos >= (CU_ID_WIDTH+1)'(NUMBER_CU))
        pos = pos - (CU_ID_WIDTH+1)'(NUMBER_CU);
      if (!found && mask[pos[CU_ID_WIDTH-1:0]]) begin
        found = 1'b1;
        idx   = pos[CU_ID_WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/cam_allocator_mres.sv
// Multi-resource CU allocation CAM: two-stage search pipeline returning fit mask and selected CU.
// Optional round-robin selection is enabled by defining CAM_ALLOC_ROUND_ROBIN_EN.
module cam_allocator_mres
  import cam_alloc_pkg::*;
#(
  parameter int CU_ID_WIDTH = DEF_CU_ID_WIDTH,
  parameter int NUMBER_CU   = DEF_NUMBER_CU
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cam_allocator_mres_if.slave    bus,
  input  logic                   wr_en,
  input  logic [CU_ID_WIDTH-1:0] wr_addr,
  input  logic [NUM_RES-1:0]     wr_chan_mask,
  input  size_t                  wr_data,
  input  logic                   inv_en,
  input  logic [CU_ID_WIDTH-1:0] inv_addr
);
  count_t               count_ram  [NUMBER_CU][NUM_RES];
  logic [NUM_RES-1:0]   chan_valid [NUMBER_CU];

  logic                   vld_p0;
  size_t                  size_p0;
  logic                   stall;
  logic                   load_p0;
  logic                   load_p1;
  logic [NUMBER_CU-1:0]   fit;
  logic [CU_ID_WIDTH-1:0] start_ptr;
  logic                   enc_found;
  logic [CU_ID_WIDTH-1:0] enc_idx;

  // Count storage carries no reset; only the valid bits qualify its contents.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_RES; k++)
      if (wr_en && wr_chan_mask[k])
        count_ram[wr_addr][k] <= wr_data[k];
  end

  // Invalidate is applied last so it overrides a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER_CU; i++)
        chan_valid[i] <= '0;
    end else begin
      if (wr_en)
        chan_valid[wr_addr] <= chan_valid[wr_addr] | wr_chan_mask;
      if (inv_en)
        chan_valid[inv_addr] <= '0;
    end
  end

  assign stall            = bus.result_valid & ~bus.result_ready;
  assign load_p1          = ~stall;
  assign load_p0          = ~vld_p0 | load_p1;
  assign bus.search_ready = load_p0;

  // Stage A: hold the accepted request until stage B can take it
  always_ff @(posedge clk) begin
    if (load_p0)
      size_p0 <= bus.search_size;
  end

  always_comb begin
    fit = '0;
    for (int i = 0; i < NUMBER_CU; i++) begin
      fit[i] = 1'b1;
      for (int k = 0; k < NUM_RES; k++)
        if (!chan_valid[i][k] || (count_ram[i][k] < size_p0[k]))
          fit[i] = 1'b0;
    end
  end

`ifdef CAM_ALLOC_ROUND_ROBIN_EN
  logic [CU_ID_WIDTH-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (bus.result_valid && bus.result_ready && bus.result_found)
      rr_ptr <= (bus.result_cu_id == CU_ID_WIDTH'(NUMBER_CU-1)) ? '0
                                                                : bus.result_cu_id + 1'b1;
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  cam_alloc_prio_enc #(
    .CU_ID_WIDTH(CU_ID_WIDTH),
    .NUMBER_CU  (NUMBER_CU)
  ) u_enc (
    .mask (fit),
    .start(start_ptr),
    .found(enc_found),
    .idx  (enc_idx)
  );

  // Stage B: register the compare outcome; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0           <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_found <= 1'b0;
      bus.result_cu_id <= '0;
      bus.result_mask  <= '0;
    end else begin
      if (load_p0)
        vld_p0 <= bus.search_valid;
      if (load_p1) begin
        bus.result_valid <= vld_p0;
        if (vld_p0) begin
          bus.result_found <= enc_found;
          bus.result_cu_id <= enc_idx;
          bus.result_mask  <= fit;
        end
      end
    end
  end
endmodule

// File: tb/tb_cam_allocator_mres.sv
// Directed self-checking bench for cam_allocator_mres (default build or CAM_ALLOC_ROUND_ROBIN_EN).
module tb_cam_allocator_mres;
  import cam_alloc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [2:0]  wr_chan_mask;
  size_t       wr_data;
  logic        inv_en;
  logic [5:0]  inv_addr;
  int          checks = 0;
  int          errors = 0;

  cam_allocator_mres_if #(.CU_ID_WIDTH(6), .NUMBER_CU(64)) bus ();

  cam_allocator_mres #(.CU_ID_WIDTH(6), .NUMBER_CU(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_chan_mask(wr_chan_mask),
    .wr_data     (wr_data),
    .inv_en      (inv_en),
    .inv_addr    (inv_addr)
  );

  always #5 clk = ~clk;

  function automatic size_t sz(input int c0, input int c1, input int c2);
    size_t s;
    s[0] = count_t'(c0);
    s[1] = count_t'(c1);
    s[2] = count_t'(c2);
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic v, input logic f,
                              input logic [5:0] cu, input logic [63:0] m);
    check({tag, "_valid"}, 64'(bus.result_valid), 64'(v));
    check({tag, "_found"}, 64'(bus.result_found), 64'(f));
    check({tag, "_cu"},    64'(bus.result_cu_id), 64'(cu));
    check({tag, "_mask"},  bus.result_mask, m);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_result("rst", 1'b0, 1'b0, 6'd0, 64'h0);
    check("rst_sready", 64'(bus.search_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cam_write(input logic [5:0] addr, input logic [2:0] cm, input size_t d);
    wr_en = 1'b1; wr_addr = addr; wr_chan_mask = cm; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_chan_mask = '0;
  endtask

  task automatic cam_inv(input logic [5:0] addr);
    inv_en = 1'b1; inv_addr = addr;
    @(negedge clk);
    inv_en = 1'b0;
  endtask

  // Accept at edge N, nothing visible after N, result visible after N+1.
  task automatic do_search(input string tag, input size_t size, input logic f,
                           input logic [5:0] cu, input logic [63:0] m);
    bus.search_size  = size;
    bus.search_valid = 1'b1;
    bus.result_ready = 1'b1;
    check({tag, "_sready"}, 64'(bus.search_ready), 64'd1);
    @(negedge clk);
    bus.search_valid = 1'b0;
    check({tag, "_lat0"}, 64'(bus.result_valid), 64'd0);
    @(negedge clk);
    check_result(tag, 1'b1, f, cu, m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.search_valid = 1'b0;
    bus.search_size  = '0;
    bus.result_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_chan_mask = '0; wr_data = '0;
    inv_en = 1'b0; inv_addr = '0;

    apply_reset();
    do_search("empty", sz(5, 5, 5), 1'b0, 6'd0, 64'h0);

    cam_write(6'd3, 3'b111, sz(10, 20, 30));
    cam_write(6'd7, 3'b111, sz(40, 40, 40));
    do_search("s15",   sz(15, 15, 15),   1'b1, 6'd7, 64'h80);
    do_search("s0",    sz(0, 0, 0),      1'b1, 6'd3, 64'h88);
    do_search("exact", sz(10, 20, 30),   1'b1, 6'd3, 64'h88);
    do_search("over1", sz(10, 21, 30),   1'b1, 6'd7, 64'h80);
    do_search("s41",   sz(41, 0, 0),     1'b0, 6'd0, 64'h0);
    do_search("smax",  sz(0, 0, 2047),   1'b0, 6'd0, 64'h0);

    // Reset while a request sits in stage A: it must never surface.
    bus.search_size = sz(0, 0, 0);
    bus.search_valid = 1'b1;
    @(negedge clk);
    bus.search_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midrst_async", 64'(bus.result_valid), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_drop1", 64'(bus.result_valid), 64'd0);
    @(negedge clk);
    check("midrst_drop2", 64'(bus.result_valid), 64'd0);

    cam_write(6'd3, 3'b010, sz(10, 20, 30));
    do_search("partial", sz(0, 0, 0), 1'b0, 6'd0, 64'h0);
    cam_write(6'd3, 3'b101, sz(10, 20, 30));
    do_search("complete", sz(0, 0, 0), 1'b1, 6'd3, 64'h8);

    wr_en = 1'b1; wr_addr = 6'd5; wr_chan_mask = 3'b111; wr_data = sz(7, 7, 7);
    inv_en = 1'b1; inv_addr = 6'd5;
    @(negedge clk);
    wr_en = 1'b0; wr_chan_mask = '0; inv_en = 1'b0;
    do_search("invwins", sz(0, 0, 0), 1'b1, 6'd3, 64'h8);
    cam_inv(6'd3);
    do_search("inv3", sz(0, 0, 0), 1'b0, 6'd0, 64'h0);

    // Write to CU9 lands on the same edge stage B captures.
    bus.search_size = sz(0, 0, 0);
    bus.search_valid = 1'b1;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.search_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd9; wr_chan_mask = 3'b111; wr_data = sz(1, 1, 1);
    @(negedge clk);
    wr_en = 1'b0; wr_chan_mask = '0;
    check_result("wrcap", 1'b1, 1'b0, 6'd0, 64'h0);
    do_search("wrseen", sz(0, 0, 0), 1'b1, 6'd9, 64'h200);

    // Stall with three queued searches; CU14 is written mid-stall.
    cam_write(6'd12, 3'b111, sz(100, 100, 100));
    bus.result_ready = 1'b0;
    bus.search_size = sz(0, 0, 0);
    bus.search_valid = 1'b1;
    @(negedge clk);
    check("stall_sready_a", 64'(bus.search_ready), 64'd1);
    bus.search_size = sz(50, 0, 0);
    @(negedge clk);
    check_result("stall_r1", 1'b1, 1'b1, 6'd9, 64'h1200);
    check("stall_sready_b", 64'(bus.search_ready), 64'd0);
    bus.search_size = sz(200, 0, 0);
    cam_write(6'd14, 3'b111, sz(60, 60, 60));
    for (int c = 0; c < 3; c++) begin
      check_result("stall_hold", 1'b1, 1'b1, 6'd9, 64'h1200);
      check("stall_sready_hold", 64'(bus.search_ready), 64'd0);
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.search_valid = 1'b0;
    check_result("drain_r2", 1'b1, 1'b1, 6'd12, 64'h5000);
    @(negedge clk);
    check_result("drain_r3", 1'b1, 1'b0, 6'd0, 64'h0);
    @(negedge clk);
    check("drain_empty", 64'(bus.result_valid), 64'd0);

    apply_reset();
    cam_write(6'd2, 3'b111, sz(1, 1, 1));
    cam_write(6'd4, 3'b111, sz(1, 1, 1));
    cam_write(6'd6, 3'b111, sz(1, 1, 1));
`ifdef CAM_ALLOC_ROUND_ROBIN_EN
    do_search("sel1", sz(1, 1, 1), 1'b1, 6'd2, 64'h54);
    do_search("sel2", sz(1, 1, 1), 1'b1, 6'd4, 64'h54);
    do_search("sel3", sz(1, 1, 1), 1'b1, 6'd6, 64'h54);
    do_search("sel4", sz(1, 1, 1), 1'b1, 6'd2, 64'h54);
`else
    do_search("sel1", sz(1, 1, 1), 1'b1, 6'd2, 64'h54);
    do_search("sel2", sz(1, 1, 1), 1'b1, 6'd2, 64'h54);
    do_search("sel3", sz(1, 1, 1), 1'b1, 6'd2, 64'h54);
    do_search("sel4", sz(1, 1, 1), 1'b1, 6'd2, 64'h54);
`endif
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
